// File: rtl/oc8051_cxram_loader.sv
// Streams program bytes into 32-bit code-memory words, one masked write per
// filled (or final partial) word, with length checking and load status.
module oc8051_cxram_loader #(
    parameter int ROMSIZE = 182,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_mask,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] byte_count
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] len_q;
    logic [31:0]       pack_data;
    logic [3:0]        pack_mask;
    logic [1:0]        lane;
    logic              accept;
    logic              len_ok;
    logic              last_byte;
    logic              word_full;
    logic [31:0]       merged_data;
    logic [3:0]        merged_mask;

    assign byte_ready  = (state == LOAD);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // The byte address of the incoming byte is the running count itself.
    assign lane        = byte_count[1:0];
    assign accept      = byte_ready && byte_valid;
    assign len_ok      = (len != '0) && (len <= ADDR_W'(ROMSIZE));
    assign last_byte   = (byte_count + ADDR_W'(1)) == len_q;
    assign word_full   = (lane == 2'd3) || last_byte;
    assign merged_data = pack_data | ({24'd0, byte_in} << {lane, 3'b000});
    assign merged_mask = pack_mask | (4'b0001 << lane);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && len_ok) state_next = LOAD;
            LOAD:    if (accept && last_byte) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Packing buffer empties on the same edge it moves to wr_data, so the
    // next byte can be taken while the write strobe is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            byte_count <= '0;
            err        <= 1'b0;
            pack_data  <= '0;
            pack_mask  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_mask    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state == IDLE && start) begin
                if (len_ok) begin
                    len_q      <= len;
                    byte_count <= '0;
                    err        <= 1'b0;
                    pack_data  <= '0;
                    pack_mask  <= '0;
                end else begin
                    err <= 1'b1;
                end
            end
            if (accept) begin
                byte_count <= byte_count + ADDR_W'(1);
                if (word_full) begin
                    wr_en     <= 1'b1;
                    wr_addr   <= byte_count >> 2;
                    wr_data   <= merged_data;
                    wr_mask   <= merged_mask;
                    pack_data <= '0;
                    pack_mask <= '0;
                end else begin
                    pack_data <= merged_data;
                    pack_mask <= merged_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_oc8051_cxram_loader.sv
// Scoreboard bench for oc8051_cxram_loader: expected writes are queued by the
// stimulus and consumed by a monitor whenever wr_en is seen.
module tb_oc8051_cxram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] byte_count;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        got;
    wr_t        want;
    int         compared   = 0;
    int         mismatched = 0;
    int         done_seen  = 0;
    logic       prev_wr_en = 1'b0;
    logic [7:0] stim [0:255];

    oc8051_cxram_loader #(.ROMSIZE(182), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .busy(busy), .done(done), .err(err), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_word(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        exp_q.push_back({a, d, m});
    endtask

    // Reference packing of stim[0..n-1] into little-endian lanes.
    task automatic push_model(input int n);
        for (int w = 0; w * 4 < n; w++) begin
            logic [31:0] d;
            logic [3:0]  m;
            d = '0;
            m = '0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < n) begin
                    d[8*k +: 8] = stim[w*4+k];
                    m[k]        = 1'b1;
                end
            end
            push_word(16'(w), d, m);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_byte_ready"}, 32'(byte_ready), 0);
        check_output({tag, "_wr_en"},      32'(wr_en),      0);
        check_output({tag, "_wr_addr"},    32'(wr_addr),    0);
        check_output({tag, "_wr_data"},    wr_data,         0);
        check_output({tag, "_wr_mask"},    32'(wr_mask),    0);
        check_output({tag, "_busy"},       32'(busy),       0);
        check_output({tag, "_done"},       32'(done),       0);
        check_output({tag, "_err"},        32'(err),        0);
        check_output({tag, "_byte_count"}, 32'(byte_count), 0);
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (wr_en) begin
                got = {wr_addr, wr_data, wr_mask};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%08h mask=%b, expected no write",
                             wr_addr, wr_data, wr_mask);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        mismatched++;
                        $display("[TB] FAIL write: got addr=%0d data=0x%08h mask=%b, expected addr=%0d data=0x%08h mask=%b",
                                 got.addr, got.data, got.mask, want.addr, want.data, want.mask);
                    end
                end
            end
            if (done) begin
                done_seen++;
                compared++;
                if (prev_wr_en !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL done_timing: got wr_en=%b in cycle before done, expected 1", prev_wr_en);
                end
            end
            prev_wr_en = wr_en;
        end
    endtask

    // Runs one load of n bytes from stim[]; optional valid gaps and stray starts.
    task automatic apply_stimulus(input int n, input bit gaps, input bit noise);
        int  i;
        int  cyc;
        int  d0;
        int  t;
        bit  acc;
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b1;
        len   = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check_output("err_after_start", 32'(err), 0);
        check_output("busy_after_start", 32'(busy), 1);
        i   = 0;
        cyc = 0;
        while (i < n && cyc < 4000) begin
            byte_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            byte_in    = stim[i];
            if (noise) begin
                start = (cyc % 3 == 1);
                len   = 16'd2;
            end
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check_output("bytes_accepted", 32'(i), 32'(n));
        t = 0;
        while (done_seen == d0 && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_output("done_pulses", 32'(done_seen - d0), 1);
        check_output("busy_after_done", 32'(busy), 0);
        check_output("byte_count_final", 32'(byte_count), 32'(n));
        check_output("writes_outstanding", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        fork
            monitor_loop();
        join_none

        rst = 1'b1; start = 1'b0; len = '0; byte_in = '0; byte_valid = 1'b0;
        #3;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_reset_values("post_reset");

        $display("[TB] single word load");
        stim[0] = 8'h02; stim[1] = 8'h00; stim[2] = 8'h10; stim[3] = 8'h75;
        push_word(16'd0, 32'h7510_0002, 4'b1111);
        apply_stimulus(4, 1'b0, 1'b0);

        $display("[TB] partial final word");
        for (int k = 0; k < 6; k++) stim[k] = 8'(k + 1);
        push_word(16'd0, 32'h0403_0201, 4'b1111);
        push_word(16'd1, 32'h0000_0605, 4'b0011);
        apply_stimulus(6, 1'b0, 1'b0);
        check_output("hold_wr_addr", 32'(wr_addr), 1);
        check_output("hold_wr_data", wr_data, 32'h0000_0605);
        check_output("hold_wr_mask", 32'(wr_mask), 32'h3);

        $display("[TB] length errors");
        @(posedge clk); #1 start = 1'b1; len = 16'd0;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("err_len0", 32'(err), 1);
        check_output("busy_len0", 32'(busy), 0);
        @(posedge clk); #1 start = 1'b1; len = 16'd183;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("err_len183", 32'(err), 1);
        check_output("busy_len183", 32'(busy), 0);
        stim[0] = 8'hAB;
        push_word(16'd0, 32'h0000_00AB, 4'b0001);
        apply_stimulus(1, 1'b0, 1'b0);

        $display("[TB] gapped stream with stray starts");
        for (int k = 0; k < 8; k++) stim[k] = 8'(8'h11 * (k + 1));
        push_word(16'd0, 32'h4433_2211, 4'b1111);
        push_word(16'd1, 32'h8877_6655, 4'b1111);
        apply_stimulus(8, 1'b1, 1'b1);

        $display("[TB] reset in the middle of a load");
        @(posedge clk); #1 start = 1'b1; len = 16'd4;
        @(posedge clk); #1 start = 1'b0;
        byte_valid = 1'b1; byte_in = 8'h5A;
        repeat (2) @(posedge clk);
        #1 byte_valid = 1'b0; rst = 1'b1;
        #2;
        check_reset_values("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
        push_word(16'd0, 32'hDDCC_BBAA, 4'b1111);
        apply_stimulus(4, 1'b0, 1'b0);

        $display("[TB] full ROMSIZE stream");
        for (int k = 0; k < 182; k++) stim[k] = 8'(k * 7 + 3);
        push_model(182);
        check_output("model_write_count", 32'(exp_q.size()), 46);
        check_output("model_last_mask", 32'(exp_q[45].mask), 32'h3);
        apply_stimulus(182, 1'b0, 1'b0);
        check_output("last_wr_addr", 32'(wr_addr), 45);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
